// File: rtl/fsm_libre_pkg.sv
// Shared definitions for the free-mode text entry FSM: states, default codes and
// printable/lowercase ranges.
package fsm_libre_pkg;

    typedef enum logic [1:0] {
        StReposo,
        StLimpiar,
        StCaptura,
        StFin
    } estado_t;

    localparam logic [7:0] COD_BORRAR_DEF = 8'h08;
    localparam logic [7:0] COD_FIN_DEF    = 8'h0D;
    localparam logic [7:0] COD_BLANCO_DEF = 8'h20;

    localparam logic [7:0] IMPR_MIN = 8'h20;
    localparam logic [7:0] IMPR_MAX = 8'h7E;

    localparam logic [7:0] MINUS_MIN  = 8'h61;
    localparam logic [7:0] MINUS_MAX  = 8'h7A;
    localparam logic [7:0] DESP_MAYUS = 8'h20;

endpackage

// File: rtl/buffer_texto.sv
// Text buffer: DEPTH x DATA_W simple dual-port RAM, synchronous write and
// registered read (a same-cycle read of the written address returns the old value).
module buffer_texto #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fsm_modo_libre_buffer.sv
// Free-mode text entry FSM: clears the buffer, captures characters with backspace,
// end key and idle timeout. Define MODO_MAYUSCULAS_EN to store lowercase as uppercase.
module fsm_modo_libre_buffer
    import fsm_libre_pkg::*;
#(
    parameter int unsigned       DATA_W         = 8,
    parameter int unsigned       DEPTH          = 16,
    parameter int unsigned       AW             = 4,
    parameter logic [DATA_W-1:0] COD_BORRAR     = DATA_W'(COD_BORRAR_DEF),
    parameter logic [DATA_W-1:0] COD_FIN        = DATA_W'(COD_FIN_DEF),
    parameter logic [DATA_W-1:0] COD_BLANCO     = DATA_W'(COD_BLANCO_DEF),
    parameter int unsigned       TIMEOUT_CICLOS = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inicio,
    input  logic [DATA_W-1:0] entrada,
    input  logic              entrada_valida,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW:0]       cuenta,
    output logic              ocupado,
    output logic              lleno,
    output logic              desborde,
    output logic              listo,
    output logic              por_timeout
);

    localparam logic [AW:0]   DEPTH_C    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   UNO_C      = (AW+1)'(1);
    localparam logic [AW-1:0] ULTIMA_DIR = AW'(DEPTH - 1);
    localparam bit            TIMEOUT_EN = (TIMEOUT_CICLOS != 0);
    localparam logic [31:0]   IDLE_MAX   = TIMEOUT_EN ? 32'(TIMEOUT_CICLOS - 1) : 32'd0;

    estado_t           estado_q, estado_d;
    logic [AW:0]       cuenta_q, cuenta_d;
    logic              desborde_q, desborde_d;
    logic              por_timeout_q, por_timeout_d;
    logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
    logic [31:0]       idle_q, idle_d;

    logic              we;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] dato_guardar;
    logic              imprimible;

    assign imprimible = (entrada >= DATA_W'(IMPR_MIN)) && (entrada <= DATA_W'(IMPR_MAX));

`ifdef MODO_MAYUSCULAS_EN
    assign dato_guardar = ((entrada >= DATA_W'(MINUS_MIN)) && (entrada <= DATA_W'(MINUS_MAX))) ?
                          (entrada - DATA_W'(DESP_MAYUS)) : entrada;
`else
    assign dato_guardar = entrada;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q      <= StReposo;
            cuenta_q      <= '0;
            desborde_q    <= 1'b0;
            por_timeout_q <= 1'b0;
            clr_ptr_q     <= '0;
            idle_q        <= '0;
        end else begin
            estado_q      <= estado_d;
            cuenta_q      <= cuenta_d;
            desborde_q    <= desborde_d;
            por_timeout_q <= por_timeout_d;
            clr_ptr_q     <= clr_ptr_d;
            idle_q        <= idle_d;
        end
    end

    always_comb begin
        estado_d      = estado_q;
        cuenta_d      = cuenta_q;
        desborde_d    = desborde_q;
        por_timeout_d = por_timeout_q;
        clr_ptr_d     = clr_ptr_q;
        idle_d        = idle_q;
        we            = 1'b0;
        wr_addr       = clr_ptr_q;
        wr_data       = COD_BLANCO;

        unique case (estado_q)
            StReposo: begin
                if (inicio) begin
                    estado_d      = StLimpiar;
                    cuenta_d      = '0;
                    desborde_d    = 1'b0;
                    por_timeout_d = 1'b0;
                    clr_ptr_d     = '0;
                end
            end
            StLimpiar: begin
                we        = 1'b1;
                clr_ptr_d = clr_ptr_q + AW'(1);
                idle_d    = '0;
                if (clr_ptr_q == ULTIMA_DIR) begin
                    estado_d = StCaptura;
                end
            end
            StCaptura: begin
                idle_d = idle_q + 32'd1;
                if (inicio) begin
                    // Restart wins over any strobe in the same cycle
                    estado_d      = StLimpiar;
                    cuenta_d      = '0;
                    desborde_d    = 1'b0;
                    por_timeout_d = 1'b0;
                    clr_ptr_d     = '0;
                end else if (entrada_valida) begin
                    idle_d = '0;
                    if (entrada == COD_FIN) begin
                        estado_d      = StFin;
                        por_timeout_d = 1'b0;
                    end else if (entrada == COD_BORRAR) begin
                        if (cuenta_q != '0) begin
                            we         = 1'b1;
                            wr_addr    = AW'(cuenta_q - UNO_C);
                            cuenta_d   = cuenta_q - UNO_C;
                            desborde_d = 1'b0;
                        end
                    end else if (imprimible) begin
                        if (cuenta_q < DEPTH_C) begin
                            we       = 1'b1;
                            wr_addr  = AW'(cuenta_q);
                            wr_data  = dato_guardar;
                            cuenta_d = cuenta_q + UNO_C;
                        end else begin
                            desborde_d = 1'b1;
                        end
                    end
                end else if (TIMEOUT_EN && (idle_q == IDLE_MAX)) begin
                    estado_d      = StFin;
                    por_timeout_d = 1'b1;
                end
            end
            StFin: begin
                estado_d = StReposo;
            end
            default: begin
                estado_d = StReposo;
            end
        endcase
    end

    buffer_texto #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_buffer (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign cuenta      = cuenta_q;
    assign ocupado     = (estado_q == StLimpiar) || (estado_q == StCaptura);
    assign lleno       = (cuenta_q == DEPTH_C);
    assign desborde    = desborde_q;
    assign listo       = (estado_q == StFin);
    assign por_timeout = por_timeout_q;

endmodule

// File: tb/tb_fsm_modo_libre_buffer.sv
// Bench for fsm_modo_libre_buffer: directed scenarios plus a randomized entry checked
// against a character-level model of the text buffer.
module tb_fsm_modo_libre_buffer;

    localparam int TO = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       inicio = 1'b0;
    logic [7:0] entrada = 8'h00;
    logic       entrada_valida = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic [4:0] cuenta;
    logic       ocupado, lleno, desborde, listo, por_timeout;

    int checks = 0;
    int errors = 0;

    // Reference model: buffer contents, fill count, overflow flag
    logic [7:0] mdl_buf [16];
    int         mdl_cnt;
    bit         mdl_desb;

    fsm_modo_libre_buffer #(
        .TIMEOUT_CICLOS (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .inicio         (inicio),
        .entrada        (entrada),
        .entrada_valida (entrada_valida),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .cuenta         (cuenta),
        .ocupado        (ocupado),
        .lleno          (lleno),
        .desborde       (desborde),
        .listo          (listo),
        .por_timeout    (por_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] stored(input logic [7:0] c);
`ifdef MODO_MAYUSCULAS_EN
        if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
`endif
        return c;
    endfunction

    function automatic void mdl_apply(input logic [7:0] c);
        if (c == 8'h08) begin
            if (mdl_cnt > 0) begin
                mdl_cnt--;
                mdl_buf[mdl_cnt] = 8'h20;
                mdl_desb = 0;
            end
        end else if (c >= 8'h20 && c <= 8'h7E) begin
            if (mdl_cnt < 16) begin
                mdl_buf[mdl_cnt] = stored(c);
                mdl_cnt++;
            end else begin
                mdl_desb = 1;
            end
        end
    endfunction

    task automatic strobe(input logic [7:0] c);
        entrada = c;
        entrada_valida = 1'b1;
        tick();
        entrada_valida = 1'b0;
        mdl_apply(c);
    endtask

    // inicio pulse then the 16 clear cycles; returns on the first CAPTURA cycle
    task automatic start_entry();
        inicio = 1'b1;
        tick();
        inicio = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 16; i++) mdl_buf[i] = 8'h20;
        mdl_cnt = 0;
        mdl_desb = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({cuenta, ocupado, lleno, desborde, listo, por_timeout, rd_data} !== 18'd0) begin
            $display("FAIL reset: cuenta=%0d ocu=%b lle=%b des=%b lis=%b pto=%b rd=%h exp all 0",
                     cuenta, ocupado, lleno, desborde, listo, por_timeout, rd_data);
            errors++;
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_clear_load();
        start_entry();
        checks++;
        if (ocupado !== 1'b1 || cuenta !== 5'd0) begin
            $display("FAIL clear_enter: ocupado=%b cuenta=%0d exp 1/0", ocupado, cuenta);
            errors++;
        end
        strobe(8'd65); strobe(8'd66); strobe(8'd67); strobe(8'd68);
        checks++;
        if (cuenta !== 5'd4) begin
            $display("FAIL load_cuenta: got %0d exp 4", cuenta);
            errors++;
        end
        for (int a = 0; a < 5; a++) begin
            rd_addr = 4'(a);
            tick();
            checks++;
            if (rd_data !== mdl_buf[a]) begin
                $display("FAIL load_read[%0d]: got %h exp %h", a, rd_data, mdl_buf[a]);
                errors++;
            end
        end
    endtask

    task automatic test_backspace();
        strobe(8'h08); strobe(8'h08);
        checks++;
        if (cuenta !== 5'd2) begin
            $display("FAIL bs_cuenta: got %0d exp 2", cuenta);
            errors++;
        end
        for (int a = 0; a < 4; a++) begin
            rd_addr = 4'(a);
            tick();
            checks++;
            if (rd_data !== mdl_buf[a]) begin
                $display("FAIL bs_read[%0d]: got %h exp %h", a, rd_data, mdl_buf[a]);
                errors++;
            end
        end
        strobe(8'h08); strobe(8'h08); strobe(8'h08);
        checks++;
        if (cuenta !== 5'd0) begin
            $display("FAIL bs_empty: got %0d exp 0", cuenta);
            errors++;
        end
    endtask

    task automatic test_full_overflow();
        repeat (17) strobe(8'h41);
        checks++;
        if (cuenta !== 5'd16 || lleno !== 1'b1 || desborde !== 1'b1) begin
            $display("FAIL full: cuenta=%0d lleno=%b desborde=%b exp 16/1/1", cuenta, lleno, desborde);
            errors++;
        end
        strobe(8'h08);
        checks++;
        if (cuenta !== 5'd15 || lleno !== 1'b0 || desborde !== 1'b0) begin
            $display("FAIL full_bs: cuenta=%0d lleno=%b desborde=%b exp 15/0/0", cuenta, lleno, desborde);
            errors++;
        end
    endtask

    task automatic test_finish();
        strobe(8'd13);
        checks++;
        if (listo !== 1'b1 || ocupado !== 1'b0 || por_timeout !== 1'b0) begin
            $display("FAIL fin_pulse: listo=%b ocupado=%b pto=%b exp 1/0/0", listo, ocupado, por_timeout);
            errors++;
        end
        tick();
        checks++;
        if (listo !== 1'b0) begin
            $display("FAIL fin_len: listo=%b exp 0", listo);
            errors++;
        end
        entrada = 8'd65;
        entrada_valida = 1'b1;
        tick();
        entrada_valida = 1'b0;
        checks++;
        if (cuenta !== 5'(mdl_cnt) || ocupado !== 1'b0) begin
            $display("FAIL fin_ignore: cuenta=%0d ocupado=%b exp %0d/0", cuenta, ocupado, mdl_cnt);
            errors++;
        end
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            tick();
            checks++;
            if (rd_data !== mdl_buf[a]) begin
                $display("FAIL fin_keep[%0d]: got %h exp %h", a, rd_data, mdl_buf[a]);
                errors++;
            end
        end
    endtask

    task automatic test_timeout();
        int early;
        start_entry();
        early = 0;
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            if (listo !== 1'b0 || ocupado !== 1'b1) early++;
        end
        checks++;
        if (early != 0) begin
            $display("FAIL to_early: %0d cycles with listo/ocupado wrong, exp 0", early);
            errors++;
        end
        tick();
        checks++;
        if (listo !== 1'b1 || por_timeout !== 1'b1) begin
            $display("FAIL to_pulse: listo=%b pto=%b exp 1/1", listo, por_timeout);
            errors++;
        end
        tick();
        checks++;
        if (listo !== 1'b0 || por_timeout !== 1'b1 || ocupado !== 1'b0) begin
            $display("FAIL to_hold: listo=%b pto=%b ocupado=%b exp 0/1/0", listo, por_timeout, ocupado);
            errors++;
        end
    endtask

    task automatic test_restart_reset();
        start_entry();
        checks++;
        if (por_timeout !== 1'b0) begin
            $display("FAIL rs_pto_clear: got %b exp 0", por_timeout);
            errors++;
        end
        repeat (5) strobe(8'h61);
        inicio = 1'b1;
        entrada = 8'h5A;
        entrada_valida = 1'b1;
        tick();
        inicio = 1'b0;
        entrada_valida = 1'b0;
        checks++;
        if (cuenta !== 5'd0 || ocupado !== 1'b1) begin
            $display("FAIL restart: cuenta=%0d ocupado=%b exp 0/1", cuenta, ocupado);
            errors++;
        end
        repeat (5) tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (ocupado !== 1'b0 || cuenta !== 5'd0 || rd_data !== 8'h00) begin
            $display("FAIL async_reset: ocupado=%b cuenta=%0d rd=%h exp 0/0/00", ocupado, cuenta, rd_data);
            errors++;
        end
        tick();
        reset = 1'b0;
        tick();
        start_entry();
        strobe(8'h61);
        strobe(8'd13);
        rd_addr = 4'd0;
        tick();
        checks++;
        if (rd_data !== mdl_buf[0]) begin
            $display("FAIL case_map: got %h exp %h", rd_data, mdl_buf[0]);
            errors++;
        end
    endtask

    task automatic test_random();
        logic [7:0] c;
        start_entry();
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0: c = 8'h08;
                1: begin
                    c = 8'($urandom_range(0, 31));
                    if (c == 8'h0D) c = 8'h01;
                end
                2: c = 8'($urandom_range(8'h7F, 8'hFF));
                default: c = 8'($urandom_range(8'h20, 8'h7E));
            endcase
            repeat ($urandom_range(0, 3)) tick();
            strobe(c);
            checks++;
            if (cuenta !== 5'(mdl_cnt) || lleno !== (mdl_cnt == 16) || desborde !== mdl_desb) begin
                $display("FAIL rnd[%0d] code %h: cuenta=%0d lleno=%b des=%b exp %0d/%b/%b",
                         i, c, cuenta, lleno, desborde, mdl_cnt, mdl_cnt == 16, mdl_desb);
                errors++;
            end
        end
        strobe(8'd13);
        tick();
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            tick();
            checks++;
            if (rd_data !== mdl_buf[a]) begin
                $display("FAIL rnd_read[%0d]: got %h exp %h", a, rd_data, mdl_buf[a]);
                errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear_load();
        test_backspace();
        test_full_overflow();
        test_finish();
        test_timeout();
        test_restart_reset();
        repeat (3) test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/fsm_modo_libre_buffer.md
Name: fsm_modo_libre_buffer

Overview:
- Parametrised successor of the free-mode entry FSM. Captures character codes typed by the user into an on-chip text buffer. Handles backspace and an end-of-entry key, and reports fill level plus an inactivity timeout.
- Sits between the keyboard/ASCII decoder and the display/text renderer. The renderer reads the buffer via an independent registered read port.

Parameters:
- DATA_W, 8, character code width (bits)
- DEPTH, 16, buffer capacity in characters (power of 2, >= 2)
- AW, 4, address width, equal to log2(DEPTH)
- COD_BORRAR, 8'h08, backspace code
- COD_FIN, 8'h0D, end-of-entry code
- COD_BLANCO, 8'h20, fill code written by clear and backspace
- TIMEOUT_CICLOS, 1000000, idle cycles in CAPTURA before forced finish (0 disables)

Ports:
- clk, in, 1, system clock, rising edge
- reset, in, 1, asynchronous, active-high reset
- inicio, in, 1, start request (level sampled each cycle)
- entrada, in, DATA_W, character code
- entrada_valida, in, 1, one-cycle strobe qualifying entrada
- rd_addr, in, AW, display read address
- rd_data, out, DATA_W, buffer[rd_addr], registered, 1-cycle latency
- cuenta, out, AW+1, characters stored (0..DEPTH)
- ocupado, out, 1, high in LIMPIAR or CAPTURA
- lleno, out, 1, cuenta == DEPTH
- desborde, out, 1, sticky: printable char rejected because buffer full
- listo, out, 1, one-cycle pulse when entry ends
- por_timeout, out, 1, held with last result: entry ended by timeout

Behaviour:
- Reset (async): state=REPOSO, cuenta=0, desborde=0, listo=0, por_timeout=0, rd_data=0. Buffer contents are undefined until the first LIMPIAR.
- States: REPOSO, LIMPIAR, CAPTURA, FIN.
- REPOSO:
  - ocupado=0; buffer and cuenta hold the last entry.
  - inicio=1 -> LIMPIAR.
- LIMPIAR:
  - Clear pointer runs 0..DEPTH-1 over DEPTH cycles, writing COD_BLANCO.
  - On entry: cuenta=0, desborde=0, por_timeout=0.
  - Strobes are ignored. After the last address -> CAPTURA.
- CAPTURA: on a cycle with entrada_valida=1, priority order:
  1. inicio=1 -> LIMPIAR (restart; the strobe is dropped). This applies in every cycle of CAPTURA, strobe or not.
  2. entrada==COD_FIN -> FIN.
  3. entrada==COD_BORRAR:
     - cuenta>0: write COD_BLANCO at cuenta-1, cuenta-=1, desborde=0.
     - cuenta==0: no-op.
  4. Printable code (0x20..0x7E):
     - cuenta<DEPTH: write at address cuenta, cuenta+=1.
     - else: desborde=1, buffer unchanged.
  5. Any other code: ignored.
- Timing: the write and the cuenta update are visible on the clock edge that samples the strobe. The idle counter resets on every accepted strobe.
- Timeout: idle counter reaching TIMEOUT_CICLOS-1 -> FIN with por_timeout=1.
- FIN: single cycle, listo=1 -> REPOSO. inicio during FIN is ignored.
- Address arithmetic is modulo DEPTH. No wrap-around of cuenta: it saturates at DEPTH.
- Read port is independent of state. A read of an address being written in the same cycle returns the old value.
- Reset mid-LIMPIAR or mid-CAPTURA: immediate return to REPOSO with reset values.

Optional Feature:
- MODO_MAYUSCULAS_EN defined: codes 0x61..0x7A are stored as code-0x20 (uppercase). The comparison against COD_FIN and COD_BORRAR uses the raw code.
- Undefined: codes are stored unmodified.

Decomposition:
- Shared package fsm_libre_pkg holds:
  - state enum/localparams (REPOSO, LIMPIAR, CAPTURA, FIN)
  - default codes COD_BORRAR, COD_FIN, COD_BLANCO
  - printable range bounds 0x20/0x7E
- One sub-module, buffer_texto: DEPTH x DATA_W simple dual-port RAM with a synchronous write and a registered read port.
- The FSM, counters and timeout stay in the top.

Test Plan:
- Clear and load: reset, inicio pulse, wait 16 cycles, strobe 65,66,67,68 -> cuenta=4; reading addresses 0..3 returns 65,66,67,68; address 4 returns 0x20.
- Backspace: after "ABCD", strobe 8 twice -> cuenta=2, addresses 2 and 3 = 0x20. At cuenta=0, strobe 8 -> cuenta stays 0.
- Full and overflow: 17 strobes of 0x41 -> cuenta=16, lleno=1, desborde=1. Then strobe 8 -> cuenta=15, desborde=0.
- Finish: strobe 13 -> listo high exactly 1 cycle, ocupado=0, buffer retained, a further strobe of 65 is ignored.
- Timeout: TIMEOUT_CICLOS=50, no strobes after entering CAPTURA -> listo pulse at cycle 50, por_timeout=1.
- Restart/reset: inicio during CAPTURA with cuenta=5 -> LIMPIAR, cuenta=0. Async reset asserted mid-LIMPIAR -> REPOSO immediately. With MODO_MAYUSCULAS_EN, strobe 0x61 -> stored 0x41.
